// File: rtl/csa_mult_pkg.sv
// Shared types and helpers for the carry-save sequential multiplier.
package csa_mult_pkg;

  localparam int unsigned N_DEF = 16;
  localparam int unsigned PW    = 2 * N_DEF;
  localparam int unsigned CW    = $clog2(N_DEF);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE
  } state_e;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/csa_seq_multiplier_compress_row.sv
// One W-wide row of 3:2 full-adder cells; the carry vector leaves pre-shifted by one.
module csa_compress_row
  import csa_mult_pkg::*;
#(
  parameter int unsigned W = PW
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  // The top cell's majority would shift out of the word, so it is never built.
  logic [W-2:0] w_maj;

  for (genvar i = 0; i < W - 1; i++) begin : g_cell
    assign w_maj[i] = maj3(x[i], y[i], z[i]);
  end

  assign s = x ^ y ^ z;
  assign c = {w_maj, 1'b0};

endmodule

// File: rtl/csa_seq_multiplier.sv
// Sequential unsigned N x N multiplier: one carry-save row per cycle, then one resolve add.
// Define CSA_MULT_EARLY_EXIT_EN to leave ACCUM as soon as the remaining multiplier bits are zero.
module csa_seq_multiplier
  import csa_mult_pkg::*;
#(
  parameter int unsigned N = N_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int unsigned P_W   = 2 * N;
  localparam int unsigned CNT_W = $clog2(N);

  state_e           r_state;
  state_e           w_next;
  logic [P_W-1:0]   r_a_sh;
  logic [N-1:0]     r_b_sh;
  logic [P_W-1:0]   r_sum;
  logic [P_W-1:0]   r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [P_W-1:0]   w_pp;
  logic [P_W-1:0]   w_s;
  logic [P_W-1:0]   w_c;
  logic             w_last;

`ifdef CSA_MULT_EARLY_EXIT_EN
  assign w_last = (r_cnt == CNT_W'(N - 1)) || (r_b_sh[N-1:1] == '0);
`else
  assign w_last = (r_cnt == CNT_W'(N - 1));
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = ACCUM;
      ACCUM:   if (w_last) w_next = RESOLVE;
      RESOLVE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state != IDLE);
  assign w_pp = r_b_sh[0] ? r_a_sh : '0;

  csa_compress_row #(.W(P_W)) u_row (
    .x (r_sum),
    .y (r_carry),
    .z (w_pp),
    .s (w_s),
    .c (w_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum   <= '0;
      r_carry <= '0;
      r_cnt   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sum   <= '0;
            r_carry <= '0;
            r_cnt   <= '0;
          end
        end
        ACCUM: begin
          r_sum   <= w_s;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CNT_W'(1);
        end
        RESOLVE: begin
          product <= r_sum + r_carry;
          done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the operand shifters are always loaded on an accepted start, so they carry no reset.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && start) begin
      r_a_sh <= {{N{1'b0}}, a};
      r_b_sh <= b;
    end else if (r_state == ACCUM) begin
      r_a_sh <= r_a_sh << 1;
      r_b_sh <= r_b_sh >> 1;
    end
  end

endmodule
